// File: rtl/seg_led_scan_ctrl.sv
// Six-digit common-anode seven-segment scan controller with a frame-coherent
// shadow of the displayed value and a load/ack update handshake.
module seg_led_scan_ctrl #(
    parameter int unsigned CLK_DIV      = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [23:0] data,
    input  logic [5:0]  dp_mask,
    input  logic [5:0]  blank_mask,
    input  logic        load,
    output logic        load_ack,
    output logic        frame_done,
    output logic [5:0]  sel,
    output logic [7:0]  seg_led
);

    localparam int unsigned CW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
    localparam logic [2:0]    DIG_LAST  = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DRIVE
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    dig, dig_n;
    logic [23:0]   sh_data, sh_data_n;
    logic [5:0]    sh_dp, sh_dp_n;
    logic [5:0]    sh_blank, sh_blank_n;
    logic          load_ack_n, frame_done_n;
    logic [5:0]    sel_n;
    logic [7:0]    seg_led_n;
    logic          boundary;
    logic [3:0]    nib;

    // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble
    function automatic logic [6:0] hex_code(input logic [3:0] n);
        logic [6:0] c;
        case (n)
            4'h0: c = 7'h40;
            4'h1: c = 7'h79;
            4'h2: c = 7'h24;
            4'h3: c = 7'h30;
            4'h4: c = 7'h19;
            4'h5: c = 7'h12;
            4'h6: c = 7'h02;
            4'h7: c = 7'h78;
            4'h8: c = 7'h00;
            4'h9: c = 7'h10;
            4'hA: c = 7'h08;
            4'hB: c = 7'h03;
            4'hC: c = 7'h46;
            4'hD: c = 7'h21;
            4'hE: c = 7'h06;
            default: c = 7'h0E;
        endcase
        return c;
    endfunction

    // State, counters, shadow and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            dig        <= '0;
            sh_data    <= '0;
            sh_dp      <= '0;
            sh_blank   <= 6'h3F;
            load_ack   <= 1'b0;
            frame_done <= 1'b0;
            sel        <= 6'h3F;
            seg_led    <= 8'hFF;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            dig        <= dig_n;
            sh_data    <= sh_data_n;
            sh_dp      <= sh_dp_n;
            sh_blank   <= sh_blank_n;
            load_ack   <= load_ack_n;
            frame_done <= frame_done_n;
            sel        <= sel_n;
            seg_led    <= seg_led_n;
        end
    end

    // Next-state, handshake and output decode
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        dig_n        = dig;
        sh_data_n    = sh_data;
        sh_dp_n      = sh_dp;
        sh_blank_n   = sh_blank;
        load_ack_n   = 1'b0;
        frame_done_n = 1'b0;
        sel_n        = 6'h3F;
        seg_led_n    = 8'hFF;

        boundary = (state != IDLE) && (cnt == CNT_MAX) && (dig == DIG_LAST);
        nib      = 4'(sh_data >> {dig, 2'b00});

        // Shadow only changes between frames (or while idle) so a frame never tears
        if (load && !load_ack && ((state == IDLE) || boundary)) begin
            sh_data_n  = data;
            sh_dp_n    = dp_mask;
            sh_blank_n = blank_mask;
            load_ack_n = 1'b1;
        end

        frame_done_n = boundary && en;

        if (en && (state == DRIVE) && !sh_blank[dig]) begin
            sel_n     = ~(6'b1 << dig);
            seg_led_n = {~sh_dp[dig], hex_code(nib)};
        end

        if (!en) begin
            state_n = IDLE;
            cnt_n   = '0;
            dig_n   = '0;
        end else if (state == IDLE) begin
            cnt_n   = '0;
            dig_n   = '0;
            state_n = (BLANK_CYCLES > 0) ? BLANK : DRIVE;
        end else begin
            if (cnt == CNT_MAX) begin
                cnt_n = '0;
                dig_n = (dig == DIG_LAST) ? 3'd0 : dig + 3'd1;
            end else begin
                cnt_n = cnt + CW'(1);
            end
            state_n = (cnt_n < CNT_BLANK) ? BLANK : DRIVE;
        end
    end

endmodule

// File: tb/tb_seg_led_scan_ctrl.sv
// Self-checking bench for seg_led_scan_ctrl: a cycle model pushes expected
// outputs at each clock edge, a comparator pops them half a cycle later.
module tb_seg_led_scan_ctrl;

    localparam int unsigned CLK_DIV      = 8;
    localparam int unsigned BLANK_CYCLES = 2;
    localparam int unsigned FRAME        = 6 * CLK_DIV;

    typedef struct packed {
        logic [5:0] sel;
        logic [7:0] seg;
        logic       ack;
        logic       fd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [23:0] data = '0;
    logic [5:0]  dp_mask = '0;
    logic [5:0]  blank_mask = '0;
    logic        load = 1'b0;
    logic        load_ack, frame_done;
    logic [5:0]  sel;
    logic [7:0]  seg_led;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t exp_q[$];

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // reference model state
    bit          m_run = 1'b0;
    int          m_cnt = 0;
    int          m_dig = 0;
    logic [23:0] m_data = '0;
    logic [5:0]  m_dp = '0;
    logic [5:0]  m_blank = 6'h3F;
    logic        m_ack = 1'b0;

    seg_led_scan_ctrl #(
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .data       (data),
        .dp_mask    (dp_mask),
        .blank_mask (blank_mask),
        .load       (load),
        .load_ack   (load_ack),
        .frame_done (frame_done),
        .sel        (sel),
        .seg_led    (seg_led)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: predicts the registered outputs produced by this edge
    always @(posedge clk) begin
        exp_t e;
        bit   bnd, cap;
        logic [3:0] nib;
        if (!rst_n) begin
            m_run = 1'b0; m_cnt = 0; m_dig = 0;
            m_data = '0; m_dp = '0; m_blank = 6'h3F; m_ack = 1'b0;
        end else begin
            bnd = m_run && (m_cnt == CLK_DIV - 1) && (m_dig == 5);
            cap = load && !m_ack && (!m_run || bnd);
            e.ack = cap;
            e.fd  = bnd && en;
            e.sel = 6'h3F;
            e.seg = 8'hFF;
            if (en && m_run && (m_cnt >= BLANK_CYCLES) && !m_blank[m_dig]) begin
                nib   = m_data[4*m_dig +: 4];
                e.sel = ~(6'b1 << m_dig);
                e.seg = {~m_dp[m_dig], hex_tab[nib]};
            end
            exp_q.push_back(e);
            if (cap) begin
                m_data = data; m_dp = dp_mask; m_blank = blank_mask;
            end
            m_ack = cap;
            if (!en) begin
                m_run = 1'b0; m_cnt = 0; m_dig = 0;
            end else if (!m_run) begin
                m_run = 1'b1; m_cnt = 0; m_dig = 0;
            end else if (m_cnt == CLK_DIV - 1) begin
                m_cnt = 0;
                m_dig = (m_dig + 1) % 6;
            end else begin
                m_cnt++;
            end
        end
    end

    // Comparator: scoreboard pop half a cycle after each edge
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sel", 32'(sel), 32'(e.sel));
            check("seg_led", 32'(seg_led), 32'(e.seg));
            check("load_ack", 32'(load_ack), 32'(e.ack));
            check("frame_done", 32'(frame_done), 32'(e.fd));
        end
    end

    task automatic do_load(input logic [23:0] d, input logic [5:0] dp, input logic [5:0] bl,
                           input int budget);
        int waited;
        data = d; dp_mask = dp; blank_mask = bl; load = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!load_ack && waited < budget);
        if (!load_ack) check("load_ack_timeout", 32'(load_ack), 32'd1);
        load = 1'b0;
    endtask

    task automatic wait_fd(input int budget);
        int waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!frame_done && waited < budget);
        if (!frame_done) check("frame_done_timeout", 32'(frame_done), 32'd1);
    endtask

    initial begin
        int first, npulse, bad, lit2;

        repeat (3) @(negedge clk);
        check("rst_sel", 32'(sel), 32'h3F);
        check("rst_seg", 32'(seg_led), 32'hFF);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // idle load: ack exactly one cycle later, display stays dark
        data = 24'hFEDCBA; dp_mask = '0; blank_mask = '0; load = 1'b1;
        @(negedge clk);
        check("idle_ack", 32'(load_ack), 32'd1);
        check("idle_sel", 32'(sel), 32'h3F);
        load = 1'b0;
        repeat (3) @(negedge clk);

        // scan order and frame period
        do_load(24'h543210, 6'b000100, 6'b000000, 4);
        en = 1'b1;
        first = -1; npulse = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (frame_done) begin
                if (first >= 0) check("fd_period", 32'(i - first), 32'(FRAME));
                else first = i;
                npulse++;
            end
        end
        check("fd_count", 32'(npulse), 32'd2);

        // coherent update requested in the digit-2 slot lands at the wrap
        wait_fd(2 * FRAME);
        repeat (2 * CLK_DIV + 3) @(negedge clk);
        do_load(24'h999999, 6'b000000, 6'b000000, 2 * FRAME);
        check("ack_at_wrap", 32'(frame_done), 32'd1);
        repeat (FRAME + 4) @(negedge clk);

        // blank mask on digits 0 and 5
        do_load(24'h543210, 6'b000000, 6'b100001, 2 * FRAME);
        bad = 0; lit2 = 0;
        for (int i = 0; i < FRAME + 8; i++) begin
            @(negedge clk);
            if (!sel[0] || !sel[5]) bad++;
            if (!sel[2]) lit2++;
        end
        check("blank_sel_05", 32'(bad), 32'd0);
        check("blank_dig2_lit", 32'(lit2), 32'(CLK_DIV - BLANK_CYCLES));

        // disable during the digit-3 drive window
        do_load(24'h543210, 6'b000000, 6'b000000, 2 * FRAME);
        wait_fd(2 * FRAME);
        repeat (3 * CLK_DIV + 4) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("dis_sel", 32'(sel), 32'h3F);
        check("dis_seg", 32'(seg_led), 32'hFF);
        npulse = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (frame_done) npulse++;
        end
        check("dis_no_fd", 32'(npulse), 32'd0);
        en = 1'b1;
        repeat (FRAME + 4) @(negedge clk);

        // asynchronous reset while a digit is driven
        wait_fd(2 * FRAME);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("async_rst_sel", 32'(sel), 32'h3F);
        check("async_rst_seg", 32'(seg_led), 32'hFF);
        check("async_rst_ack", 32'(load_ack), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (sel != 6'h3F) bad++;
        end
        check("post_rst_dark", 32'(bad), 32'd0);
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
